// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: RV32I opcodes, forwarding/FSM enums and the forwarding
// priority helper shared by the hazard controller and decode logic.
package hazard_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN,
        LDSTALL,
        REDIR
    } haz_state_e;

    // MEM is younger than WB, so it wins when both write the same register.
    function automatic fwd_sel_e fwd_pick(
        input logic       mem_we,
        input logic [4:0] mem_rd,
        input logic       wb_we,
        input logic [4:0] wb_rd,
        input logic [4:0] rs
    );
        return (mem_we && mem_rd != 5'd0 && mem_rd == rs) ? FWD_MEM :
               (wb_we  && wb_rd  != 5'd0 && wb_rd  == rs) ? FWD_WB  : FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_reg_use_dec.sv
// reg_use_dec: extracts rs1/rs2 and whether the instruction actually reads them.
module reg_use_dec
    import hazard_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        use_rs1,
    output logic        use_rs2
);

    logic [6:0] op;
    logic       unused_bits;

    assign op          = instr[6:0];
    assign rs1         = instr[19:15];
    assign rs2         = instr[24:20];
    assign use_rs1     = op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
    assign use_rs2     = op inside {OP_R, OP_STORE, OP_BRANCH};
    assign unused_bits = ^{instr[31:25], instr[14:7]};

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall / redirect flush sequencer and EX forwarding selects.
// Optional HAZ_PERF_CNT_EN adds free-running stall and bubble counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned REDIRECT_BUBBLES  = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_id_instr,
    input  logic        i_id_valid,
    input  logic        i_ex_valid,
    input  logic        i_ex_is_load,
    input  logic [4:0]  i_ex_rd,
    input  logic [4:0]  i_ex_rs1,
    input  logic [4:0]  i_ex_rs2,
    input  logic        i_ex_redirect,
    input  logic        i_mem_regwrite,
    input  logic [4:0]  i_mem_rd,
    input  logic        i_wb_regwrite,
    input  logic [4:0]  i_wb_rd,
    output logic        o_stall_pc,
    output logic        o_stall_id,
    output logic        o_flush_id,
    output logic        o_flush_ex,
    output logic [1:0]  o_fwd_a,
    output logic [1:0]  o_fwd_b
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0] o_stall_cnt,
    output logic [31:0] o_flush_cnt
`endif
);

    localparam logic [2:0] LD_LOAD = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [2:0] RB_LOAD = 3'(REDIRECT_BUBBLES - 1);

    haz_state_e state, state_nx;
    logic [2:0] cnt, cnt_nx;
    logic [4:0] rs1, rs2;
    logic       use_rs1, use_rs2;
    logic       lu, rd_ev;
    logic       stall, flush_id, flush_ex;

    reg_use_dec u_dec (
        .instr  (i_id_instr),
        .rs1    (rs1),
        .rs2    (rs2),
        .use_rs1(use_rs1),
        .use_rs2(use_rs2)
    );

    assign lu = i_id_valid && i_ex_valid && i_ex_is_load && i_ex_rd != 5'd0 &&
                ((use_rs1 && rs1 == i_ex_rd) || (use_rs2 && rs2 == i_ex_rd));
    assign rd_ev = i_ex_redirect && i_ex_valid;

    // A redirect overrides everything: the stalled/flushed work is wrong-path anyway.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        stall    = 1'b0;
        flush_id = 1'b0;
        flush_ex = 1'b0;
        if (rd_ev) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
            state_nx = (REDIRECT_BUBBLES > 1) ? REDIR : RUN;
            cnt_nx   = RB_LOAD;
        end else if (state == RUN) begin
            if (lu) begin
                stall    = 1'b1;
                flush_ex = 1'b1;
                state_nx = (LOAD_STALL_CYCLES > 1) ? LDSTALL : RUN;
                cnt_nx   = LD_LOAD;
            end
        end else begin
            stall    = state == LDSTALL;
            flush_ex = state == LDSTALL;
            flush_id = state != LDSTALL;
            cnt_nx   = cnt - 3'd1;
            state_nx = (cnt <= 3'd1) ? RUN : state;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Outputs are gated by reset so they drop the instant reset asserts.
    assign o_stall_pc = i_rst_n && stall;
    assign o_stall_id = i_rst_n && stall;
    assign o_flush_id = i_rst_n && flush_id;
    assign o_flush_ex = i_rst_n && flush_ex;
    assign o_fwd_a    = i_rst_n ? fwd_pick(i_mem_regwrite, i_mem_rd, i_wb_regwrite, i_wb_rd, i_ex_rs1) : FWD_RF;
    assign o_fwd_b    = i_rst_n ? fwd_pick(i_mem_regwrite, i_mem_rd, i_wb_regwrite, i_wb_rd, i_ex_rs2) : FWD_RF;

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stall_cnt <= 32'd0;
            o_flush_cnt <= 32'd0;
        end else begin
            o_stall_cnt <= o_stall_cnt + {31'd0, o_stall_pc};
            o_flush_cnt <= o_flush_cnt + {31'd0, o_flush_ex};
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: two configurations (defaults, and 3/3) driven in lockstep
// against a remaining-cycles reference model plus a directed vector table.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr;
    logic        id_valid, ex_valid, ex_is_load, redirect, mw, ww;
    logic [4:0]  ex_rd, ex_rs1, ex_rs2, mrd, wrd;
    logic        st1, si1, fi1, fe1, st3, si3, fi3, fe3;
    logic [1:0]  fa1, fb1, fa3, fb3;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] sc1, fc1, sc3, fc3;
`endif

    int checks = 0, fails = 0;
    int s1 = 0, r1 = 0, s3 = 0, r3 = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_id_instr(instr), .i_id_valid(id_valid),
        .i_ex_valid(ex_valid), .i_ex_is_load(ex_is_load), .i_ex_rd(ex_rd),
        .i_ex_rs1(ex_rs1), .i_ex_rs2(ex_rs2), .i_ex_redirect(redirect),
        .i_mem_regwrite(mw), .i_mem_rd(mrd), .i_wb_regwrite(ww), .i_wb_rd(wrd),
        .o_stall_pc(st1), .o_stall_id(si1), .o_flush_id(fi1), .o_flush_ex(fe1),
        .o_fwd_a(fa1), .o_fwd_b(fb1)
`ifdef HAZ_PERF_CNT_EN
        , .o_stall_cnt(sc1), .o_flush_cnt(fc1)
`endif
    );

    hazard_ctrl #(.LOAD_STALL_CYCLES(3), .REDIRECT_BUBBLES(3)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_id_instr(instr), .i_id_valid(id_valid),
        .i_ex_valid(ex_valid), .i_ex_is_load(ex_is_load), .i_ex_rd(ex_rd),
        .i_ex_rs1(ex_rs1), .i_ex_rs2(ex_rs2), .i_ex_redirect(redirect),
        .i_mem_regwrite(mw), .i_mem_rd(mrd), .i_wb_regwrite(ww), .i_wb_rd(wrd),
        .o_stall_pc(st3), .o_stall_id(si3), .o_flush_id(fi3), .o_flush_ex(fe3),
        .o_fwd_a(fa3), .o_fwd_b(fb3)
`ifdef HAZ_PERF_CNT_EN
        , .o_stall_cnt(sc3), .o_flush_cnt(fc3)
`endif
    );

    typedef struct {
        logic [31:0] instr;
        logic        idv, exv, ld, redir;
        logic [4:0]  exrd;
        logic        mw;
        logic [4:0]  mrd;
        logic        ww;
        logic [4:0]  wrd, rs1, rs2;
        logic [3:0]  w;
        logic [3:0]  wf;
    } vec_t;

    task automatic chk(input string n, input logic [3:0] a, input logic [3:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    function automatic logic model_lu();
        logic [6:0] op = instr[6:0];
        logic u1 = op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
        logic u2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
        return id_valid && ex_valid && ex_is_load && ex_rd != 5'd0 &&
               ((u1 && instr[19:15] == ex_rd) || (u2 && instr[24:20] == ex_rd));
    endfunction

    function automatic logic [1:0] mfwd(input logic [4:0] rs);
        if (!rst_n) return 2'b00;
        if (mw && mrd != 5'd0 && mrd == rs) return 2'b01;
        if (ww && wrd != 5'd0 && wrd == rs) return 2'b10;
        return 2'b00;
    endfunction

    // s = stall cycles still owed, r = flush_id cycles still owed after this one.
    task automatic model(input int lsc, input int rb, inout int s, inout int r,
                         output logic st, output logic fi, output logic fe);
        st = 1'b0; fi = 1'b0; fe = 1'b0;
        if (!rst_n) begin
            s = 0; r = 0;
        end else if (redirect && ex_valid) begin
            fi = 1'b1; fe = 1'b1; r = rb - 1; s = 0;
        end else if (r > 0) begin
            fi = 1'b1; r--;
        end else if (s > 0) begin
            st = 1'b1; fe = 1'b1; s--;
        end else if (model_lu()) begin
            st = 1'b1; fe = 1'b1; s = lsc - 1;
        end
    endtask

    task automatic cyc(input int w1 = -1, input int w3 = -1, input int wf = -1);
        logic st, fi, fe;
        @(negedge clk);
        model(1, 2, s1, r1, st, fi, fe);
        chk("d1_ctl", {st1, si1, fi1, fe1}, {st, st, fi, fe});
        chk("d1_fwd", {fa1, fb1}, {mfwd(ex_rs1), mfwd(ex_rs2)});
        model(3, 3, s3, r3, st, fi, fe);
        chk("d3_ctl", {st3, si3, fi3, fe3}, {st, st, fi, fe});
        chk("d3_fwd", {fa3, fb3}, {mfwd(ex_rs1), mfwd(ex_rs2)});
        if (w1 >= 0) chk("d1_seq", {st1, si1, fi1, fe1}, w1[3:0]);
        if (w3 >= 0) chk("d3_seq", {st3, si3, fi3, fe3}, w3[3:0]);
        if (wf >= 0) chk("fwd_tbl", {fa1, fb1}, wf[3:0]);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        instr = 32'h0000_0013; id_valid = 0; ex_valid = 0; ex_is_load = 0; redirect = 0;
        ex_rd = 0; ex_rs1 = 0; ex_rs2 = 0; mw = 0; mrd = 0; ww = 0; wrd = 0;
    endtask

    task automatic set_lu();
        instr = 32'h0062_83B3; id_valid = 1; ex_valid = 1; ex_is_load = 1; ex_rd = 5'd5;
    endtask

    vec_t tbl[16];
    logic [6:0] ops[10];

    initial begin
        // Each row starts in RUN on the default-parameter instance.
        tbl[0]  = '{32'h006283B3, 1, 1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 4'b1101, 4'h0};
        tbl[1]  = '{32'h000122B7, 1, 1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 4'b0000, 4'h0};
        tbl[2]  = '{32'h006283B3, 0, 1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 4'b0000, 4'h0};
        tbl[3]  = '{32'h006003B3, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'h0};
        tbl[4]  = '{32'h005303B3, 1, 1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 4'b1101, 4'h0};
        tbl[5]  = '{32'h00530393, 1, 1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 4'b0000, 4'h0};
        tbl[6]  = '{32'h006283B3, 1, 1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 4'b0011, 4'h0};
        tbl[7]  = '{32'h006283B3, 1, 0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 4'b0000, 4'h0};
        tbl[8]  = '{32'h00000013, 0, 0, 0, 0, 0, 1, 3, 1, 3, 3, 3, 4'b0000, 4'b0101};
        tbl[9]  = '{32'h00000013, 0, 0, 0, 0, 0, 0, 3, 1, 3, 3, 3, 4'b0000, 4'b1010};
        tbl[10] = '{32'h00000013, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 4'b0000, 4'b0000};
        tbl[11] = '{32'h00000013, 0, 0, 0, 0, 0, 1, 3, 1, 4, 3, 4, 4'b0000, 4'b0110};
        tbl[12] = '{32'h00532023, 1, 1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 4'b1101, 4'h0};
        tbl[13] = '{32'h0002806F, 1, 1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 4'b0000, 4'h0};
        tbl[14] = '{32'h00028067, 1, 1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 4'b1101, 4'h0};
        tbl[15] = '{32'h00530063, 1, 1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 4'b1101, 4'h0};
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h37, 7'h17, 7'h7F};

        idle();
        set_lu();
        mw = 1; mrd = 3; ww = 1; wrd = 3; ex_rs1 = 3; ex_rs2 = 3;
        #3;
        chk("rst_ctl", {st1, si1, fi1, fe1}, 4'b0000);
        chk("rst_fwd", {fa1, fb1}, 4'b0000);
        chk("rst_ctl3", {st3, si3, fi3, fe3}, 4'b0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        cyc(0, 0);

        foreach (tbl[i]) begin
            instr = tbl[i].instr; id_valid = tbl[i].idv; ex_valid = tbl[i].exv;
            ex_is_load = tbl[i].ld; redirect = tbl[i].redir; ex_rd = tbl[i].exrd;
            mw = tbl[i].mw; mrd = tbl[i].mrd; ww = tbl[i].ww; wrd = tbl[i].wrd;
            ex_rs1 = tbl[i].rs1; ex_rs2 = tbl[i].rs2;
            cyc(int'(tbl[i].w), -1, int'(tbl[i].wf));
            idle();
            repeat (3) cyc();
        end

        // Load-use: 1 stall cycle by default, 3 with LOAD_STALL_CYCLES=3.
        set_lu();
        cyc(4'b1101, 4'b1101);
        idle();
        cyc(4'b0000, 4'b1101);
        cyc(4'b0000, 4'b1101);
        cyc(4'b0000, 4'b0000);

        // Redirect: flush_id lasts REDIRECT_BUBBLES cycles, flush_ex only the first.
        redirect = 1; ex_valid = 1;
        cyc(4'b0011, 4'b0011);
        idle();
        cyc(4'b0010, 4'b0010);
        cyc(4'b0000, 4'b0010);
        cyc(4'b0000, 4'b0000);

        // Redirect arriving while dut3 sits in LDSTALL drops the stall.
        set_lu();
        cyc(4'b1101, 4'b1101);
        idle();
        redirect = 1; ex_valid = 1;
        cyc(4'b0011, 4'b0011);
        idle();
        set_lu();
        cyc(4'b0010, 4'b0010);
        cyc(-1, 4'b0010);
        idle();
        repeat (2) cyc();

        // Asynchronous reset in the middle of an LDSTALL.
        set_lu();
        cyc(4'b1101, 4'b1101);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ctl3", {st3, si3, fi3, fe3}, 4'b0000);
        chk("midrst_ctl1", {st1, si1, fi1, fe1}, 4'b0000);
        s1 = 0; r1 = 0; s3 = 0; r3 = 0;
        cyc(0, 0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(0, 0);
        set_lu();
        cyc(4'b1101, 4'b1101);
        idle();
        repeat (3) cyc();

        for (int n = 0; n < 600; n++) begin
            instr = {$urandom_range(0, 127)} << 25;
            instr[24:20] = 5'($urandom_range(0, 3));
            instr[19:15] = 5'($urandom_range(0, 3));
            instr[14:7]  = 8'($urandom);
            instr[6:0]   = ops[$urandom_range(0, 9)];
            id_valid   = ($urandom_range(0, 3) != 0);
            ex_valid   = ($urandom_range(0, 3) != 0);
            ex_is_load = $urandom_range(0, 1) == 1;
            redirect   = ($urandom_range(0, 5) == 0);
            ex_rd  = 5'($urandom_range(0, 3));
            ex_rs1 = 5'($urandom_range(0, 3));
            ex_rs2 = 5'($urandom_range(0, 3));
            mw = $urandom_range(0, 1) == 1; mrd = 5'($urandom_range(0, 3));
            ww = $urandom_range(0, 1) == 1; wrd = 5'($urandom_range(0, 3));
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and redirect controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB).
- Decodes register usage of the ID-stage instruction.
- Detects load-use hazards and sequences multi-cycle stalls.
- Sequences branch/jump redirect flushes.
- Drives the EX-stage operand forwarding selects.
- Sits beside the ID/EX pipeline registers; its stall/flush outputs gate the PC, IF/ID and ID/EX registers.

Parameters:
- LOAD_STALL_CYCLES, 1: total cycles PC and IF/ID hold on a load-use hazard. Range 1..7.
- REDIRECT_BUBBLES, 2: total cycles IF/ID is flushed after a redirect. Covers synchronous instruction-memory latency. Range 1..7.

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  asynchronous active-low reset
- i_id_instr  in  32  instruction currently in IF/ID
- i_id_valid  in  1  IF/ID holds a real instruction
- i_ex_valid  in  1  ID/EX holds a real instruction
- i_ex_is_load  in  1  EX instruction is a load (opcode 0000011)
- i_ex_rd  in  5  EX destination register
- i_ex_rs1  in  5  EX source 1 (for forwarding)
- i_ex_rs2  in  5  EX source 2
- i_ex_redirect  in  1  EX resolved taken branch, JAL or JALR
- i_mem_regwrite  in  1  MEM stage writes rd
- i_mem_rd  in  5  MEM destination
- i_wb_regwrite  in  1  WB stage writes rd
- i_wb_rd  in  5  WB destination
- o_stall_pc  out  1  hold PC
- o_stall_id  out  1  hold IF/ID
- o_flush_id  out  1  clear IF/ID valid
- o_flush_ex  out  1  clear ID/EX valid (bubble)
- o_fwd_a  out  2  EX operand A select: 00 regfile, 01 MEM, 10 WB
- o_fwd_b  out  2  EX operand B select, same encoding

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous, active-low.
- Reset state: state=RUN, cnt=0. While i_rst_n=0, every output is forced to 0, including the forwarding selects (00).
- Source decode, from i_id_instr:
  - rs1=[19:15], rs2=[24:20].
  - use_rs1 for opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
  - use_rs2 for opcodes 0110011, 0100011, 1100011.
  - LUI, AUIPC, JAL and unknown opcodes use neither.
- x0 rule: x0 never causes a hazard or a forward.
- Load-use hazard (lu) = i_id_valid & i_ex_valid & i_ex_is_load & i_ex_rd!=0 & ((use_rs1 & rs1==i_ex_rd) | (use_rs2 & rs2==i_ex_rd)).
- Redirect (rd_ev) = i_ex_redirect & i_ex_valid.
- Forwarding (pure combinational, independent of FSM):
  - o_fwd_a=01 if i_mem_regwrite & i_mem_rd!=0 & i_mem_rd==i_ex_rs1.
  - else 10 if the same test passes against WB.
  - else 00. MEM has priority over WB.
  - o_fwd_b: identical, using i_ex_rs2.
- FSM states: RUN, LDSTALL, REDIR. 3-bit down-counter cnt.
- RUN:
  - If rd_ev: assert o_flush_id and o_flush_ex this cycle. If REDIRECT_BUBBLES>1, go to REDIR with cnt=REDIRECT_BUBBLES-1; else stay in RUN.
  - Else if lu: assert o_stall_pc, o_stall_id and o_flush_ex this cycle. If LOAD_STALL_CYCLES>1, go to LDSTALL with cnt=LOAD_STALL_CYCLES-1.
  - Redirect beats load-use in the same cycle; no stall is asserted.
- LDSTALL:
  - Assert o_stall_pc, o_stall_id, o_flush_ex.
  - cnt decrements each cycle. At cnt==1 the next state is RUN.
  - rd_ev here behaves as in RUN (flush both, enter REDIR, stall dropped).
- REDIR:
  - Assert o_flush_id only.
  - cnt decrements; at cnt==1 the next state is RUN.
  - lu is ignored in this state because IF/ID is being flushed.
  - A new rd_ev reloads cnt=REDIRECT_BUBBLES-1 and asserts o_flush_ex that cycle.
- Latency: every stall/flush output is combinational from the inputs plus registered state. Zero-cycle response on the detecting cycle.
- Mid-operation reset: asynchronous return to RUN, cnt=0, all outputs 0.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- When defined:
  - Adds ports o_stall_cnt (out, 32) and o_flush_cnt (out, 32).
  - o_stall_cnt increments on each cycle with o_stall_pc=1.
  - o_flush_cnt increments on each cycle with o_flush_ex=1.
  - Both counters wrap at 2^32 and reset to 0.
- When undefined: the ports and registers are absent. All other behaviour is identical.

Decomposition:
- Package hazard_ctrl_pkg holds:
  - opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR, OP_JAL, OP_LUI, OP_AUIPC)
  - enum fwd_sel_e {FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10}
  - enum haz_state_e {RUN, LDSTALL, REDIR}
- Sub-module reg_use_dec: combinational. Input instr[31:0]; outputs rs1, rs2, use_rs1, use_rs2. Reusable by the decode stage.

Test Plan:
- Load x5 in EX; ADD x7,x5,x6 (0x006283B3) in ID, valid → exactly 1 cycle of o_stall_pc=o_stall_id=o_flush_ex=1, then all 0 (default params).
- LOAD_STALL_CYCLES=3, same stimulus → stall/bubble held 3 consecutive cycles; FSM RUN→LDSTALL→LDSTALL→RUN.
- i_ex_redirect=1 with i_ex_valid=1, REDIRECT_BUBBLES=2 → cycle 0: flush_id=flush_ex=1; cycle 1: flush_id=1 only; cycle 2: all 0.
- Redirect and load-use in the same cycle → flush_id=flush_ex=1 and stall_pc=0.
- i_mem_rd=i_wb_rd=i_ex_rs1=3, both regwrite=1 → o_fwd_a=01. MEM regwrite=0 → 10. rd=0 with i_ex_rs1=0 → 00.
- LUI x5 (0x000122B7) in ID behind load x5 → no stall. Assert i_rst_n=0 while in LDSTALL → all outputs 0 immediately; RUN after release.
